// File: rtl/jtframe_joy_serial_rx_if.sv
// Board-side joystick chain pins plus the decoded joystick buses of
// jtframe_joy_serial_rx. The receiver uses the master view.
interface jtframe_joy_serial_rx_if;
  logic        joy_data;
  logic        joy_clk;
  logic        joy_load;
  logic [5:0]  joy1;
  logic [5:0]  joy2;
  logic        frame_stb;
  logic [15:0] raw;

  modport master (
    input  joy_data,
    output joy_clk, joy_load, joy1, joy2, frame_stb, raw
  );

  modport slave (
    output joy_data,
    input  joy_clk, joy_load, joy1, joy2, frame_stb, raw
  );
endinterface

// File: rtl/jtframe_joy_serial_rx.sv
// NeptUNO serial joystick reader: loads and clocks a 16-bit 74HC165 chain,
// deserialises it and presents two debounced active-low 6-bit joystick buses.
module jtframe_joy_serial_rx #(
  parameter int CLKDIV   = 8,
  parameter int GAPTICKS = 16,
  parameter int DEBOUNCE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  jtframe_joy_serial_rx_if.master bus
);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_FRAME,
    ST_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  gap_q, gap_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] sr_q, sr_d;
  logic [15:0] prev_q, prev_d;
  logic [15:0] raw_q, raw_d;
  logic [5:0]  joy1_q, joy1_d;
  logic [5:0]  joy2_q, joy2_d;
  logic        jclk_q, jclk_d;
  logic        load_q, load_d;
  logic        stb_q, stb_d;
  logic        tick;

  assign tick  = (div_q == 8'(CLKDIV - 1));
  assign div_d = tick ? 8'd0 : div_q + 8'd1;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    prev_d  = prev_q;
    raw_d   = raw_q;
    joy1_d  = joy1_q;
    joy2_d  = joy2_q;
    jclk_d  = jclk_q;
    load_d  = load_q;
    stb_d   = 1'b0;
    if (tick) begin
      unique case (state_q)
        // After reset load is still high here, so one extra tick is spent
        // driving it low; frames entered from GAP arrive with load already low.
        ST_LOAD: begin
          if (load_q) begin
            load_d = 1'b0;
          end else begin
            load_d  = 1'b1;
            bit_d   = 4'd0;
            state_d = ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          sr_d[bit_q] = bus.joy_data;
          jclk_d      = 1'b1;
          state_d     = ST_SHIFT_HI;
        end
        ST_SHIFT_HI: begin
          jclk_d = 1'b0;
          if (bit_q == 4'd15) begin
            state_d = ST_FRAME;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = ST_SHIFT_LO;
          end
        end
        ST_FRAME: begin
          raw_d = sr_q;
          stb_d = 1'b1;
          if (DEBOUNCE == 0 || sr_q == prev_q) begin
            joy1_d = {sr_q[5], sr_q[4], sr_q[0], sr_q[1], sr_q[2], sr_q[3]};
            joy2_d = {sr_q[13], sr_q[12], sr_q[8], sr_q[9], sr_q[10], sr_q[11]};
          end
          prev_d  = sr_q;
          gap_d   = 8'd0;
          state_d = ST_GAP;
        end
        ST_GAP: begin
          if (gap_q == 8'(GAPTICKS - 1)) begin
            gap_d   = 8'd0;
            load_d  = 1'b0;
            state_d = ST_LOAD;
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      div_q   <= 8'd0;
      gap_q   <= 8'd0;
      bit_q   <= 4'd0;
      prev_q  <= 16'hFFFF;
      raw_q   <= 16'hFFFF;
      joy1_q  <= 6'h3F;
      joy2_q  <= 6'h3F;
      jclk_q  <= 1'b0;
      load_q  <= 1'b1;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      prev_q  <= prev_d;
      raw_q   <= raw_d;
      joy1_q  <= joy1_d;
      joy2_q  <= joy2_d;
      jclk_q  <= jclk_d;
      load_q  <= load_d;
      stb_q   <= stb_d;
    end
  end

  // Shift register holds only in-flight data; it is fully rewritten every frame.
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign bus.joy_clk   = jclk_q;
  assign bus.joy_load  = load_q;
  assign bus.joy1      = joy1_q;
  assign bus.joy2      = joy2_q;
  assign bus.frame_stb = stb_q;
  assign bus.raw       = raw_q;

endmodule

// File: tb/tb_jtframe_joy_serial_rx.sv
// Bench for jtframe_joy_serial_rx: three receivers with different parameters,
// each fed by a 74HC165 chain model, checked against a word-level decoder.
module tb_jtframe_joy_serial_rx;

  logic        clk = 1'b0;
  logic        rst0, rst1, rst2;
  logic [15:0] pat [3];
  logic [15:0] sh  [3];
  logic [2:0]  jcp;
  logic [2:0]  ld, jc, stb;
  int          nchk = 0;
  int          nerr = 0;

  jtframe_joy_serial_rx_if if0 ();
  jtframe_joy_serial_rx_if if1 ();
  jtframe_joy_serial_rx_if if2 ();

  jtframe_joy_serial_rx #(.CLKDIV(8), .GAPTICKS(16), .DEBOUNCE(0)) u0 (
    .clk(clk), .rst_n(rst0), .bus(if0));
  jtframe_joy_serial_rx #(.CLKDIV(8), .GAPTICKS(16), .DEBOUNCE(1)) u1 (
    .clk(clk), .rst_n(rst1), .bus(if1));
  jtframe_joy_serial_rx #(.CLKDIV(2), .GAPTICKS(1), .DEBOUNCE(0)) u2 (
    .clk(clk), .rst_n(rst2), .bus(if2));

  assign if0.joy_data = sh[0][0];
  assign if1.joy_data = sh[1][0];
  assign if2.joy_data = sh[2][0];
  assign ld  = {if2.joy_load,  if1.joy_load,  if0.joy_load};
  assign jc  = {if2.joy_clk,   if1.joy_clk,   if0.joy_clk};
  assign stb = {if2.frame_stb, if1.frame_stb, if0.frame_stb};

  always #5 clk = ~clk;

  // Chain model: parallel load while load is low, shift toward the output on
  // each joy_clk rising edge with the cascade input tied high.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!ld[i]) sh[i] <= pat[i];
      else if (jc[i] && !jcp[i]) sh[i] <= {1'b1, sh[i][15:1]};
    end
    jcp <= jc;
  end

  function automatic logic [5:0] decode(input logic [15:0] w, input int p);
    int pos [6];
    logic [5:0] r;
    pos = '{3, 2, 1, 0, 4, 5};
    r = 6'h3F;
    for (int k = 0; k < 6; k++) r[pos[k]] = w[p*8 + k];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_stb(input int i, input string tag);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    while (n < 2000 && !ok) begin
      step();
      n++;
      if (stb[i]) ok = 1'b1;
    end
    check({tag, "_stb_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_load_fall(input int i, input string tag, output int n);
    logic p;
    bit ok;
    p = ld[i];
    n = 0;
    ok = 1'b0;
    while (n < 2000 && !ok) begin
      step();
      n++;
      if (!ld[i] && p) ok = 1'b1;
      p = ld[i];
    end
    check({tag, "_fall_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_rises(input int i, input int k, input string tag);
    logic p;
    int n, r;
    p = jc[i];
    n = 0;
    r = 0;
    while (n < 2000 && r < k) begin
      step();
      n++;
      if (jc[i] && !p) r++;
      p = jc[i];
    end
    check({tag, "_rises"}, 32'(r), 32'(k));
  endtask

  logic [15:0] m1prev, w;
  logic [5:0]  e1, e2;

  task automatic m1_frame(input logic [15:0] word);
    if (word == m1prev) begin
      e1 = decode(word, 0);
      e2 = decode(word, 1);
    end
    m1prev = word;
  endtask

  initial begin
    int n, t, lw, nrise, wbad, hw, stbt, nstb;
    logic pl, pj;

    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    pat[0] = 16'hFFFE; pat[1] = 16'hFFFF; pat[2] = 16'hFFFF;
    repeat (3) step();
    check("rst_joy1", 32'(if0.joy1), 32'h3F);
    check("rst_joy2", 32'(if0.joy2), 32'h3F);
    check("rst_raw",  32'(if0.raw),  32'hFFFF);
    check("rst_load", 32'(ld[0]),    32'd1);
    check("rst_jclk", 32'(jc[0]),    32'd0);
    check("rst_stb",  32'(stb[0]),   32'd0);

    @(negedge clk);
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    wait_load_fall(0, "first", n);
    check("first_load_cycle", 32'(n), 32'd8);

    // One full frame of u0, from load fall to the next load fall.
    t = 0; lw = 1; nrise = 0; wbad = 0; hw = 0; stbt = -1; nstb = 0;
    pl = 1'b0; pj = 1'b0;
    while (t < 1000) begin
      step();
      t++;
      if (!ld[0] && pl) break;
      if (!ld[0]) lw++;
      if (jc[0]) hw++;
      if (jc[0] && !pj) nrise++;
      if (!jc[0] && pj) begin
        if (hw != 8) wbad++;
        hw = 0;
      end
      if (stb[0]) begin
        nstb++;
        stbt = t;
      end
      pl = ld[0];
      pj = jc[0];
    end
    check("frame_period",  32'(t),     32'd400);
    check("load_low_width", 32'(lw),   32'd8);
    check("jclk_pulses",   32'(nrise), 32'd16);
    check("jclk_bad_width", 32'(wbad), 32'd0);
    check("stb_count",     32'(nstb),  32'd1);
    check("stb_latency",   32'(stbt),  32'd272);
    check("up_joy1", 32'(if0.joy1), 32'h37);
    check("up_joy2", 32'(if0.joy2), 32'h3F);
    check("up_raw",  32'(if0.raw),  32'hFFFE);

    wait_stb(0, "align0");
    pat[0] = 16'h3F3F;
    wait_stb(0, "unused");
    check("unused_joy1", 32'(if0.joy1), 32'h3F);
    check("unused_joy2", 32'(if0.joy2), 32'h3F);
    check("unused_raw",  32'(if0.raw),  32'h3F3F);

    for (int i = 0; i < 4; i++) begin
      w = 16'($urandom);
      pat[0] = w;
      wait_stb(0, "rand0");
      check("rand0_raw",  32'(if0.raw),  32'(w));
      check("rand0_joy1", 32'(if0.joy1), 32'(decode(w, 0)));
      check("rand0_joy2", 32'(if0.joy2), 32'(decode(w, 1)));
    end

    // Reset in the middle of bit 7 while joy_clk is high.
    pat[0] = 16'hFFFE;
    wait_stb(0, "pre_rst");
    check("pre_rst_joy1", 32'(if0.joy1), 32'h37);
    wait_rises(0, 8, "bit7");
    repeat (3) step();
    check("pre_rst_jclk", 32'(jc[0]), 32'd1);
    #2 rst0 = 1'b0;
    #1;
    check("midrst_joy1", 32'(if0.joy1), 32'h3F);
    check("midrst_jclk", 32'(jc[0]),    32'd0);
    check("midrst_load", 32'(ld[0]),    32'd1);
    check("midrst_raw",  32'(if0.raw),  32'hFFFF);
    @(negedge clk);
    @(negedge clk);
    rst0 = 1'b1;
    wait_load_fall(0, "rst_reload", n);
    check("rst_reload_cycle", 32'(n), 32'd8);

    // Debounced receiver.
    m1prev = 16'hFFFF; e1 = 6'h3F; e2 = 6'h3F;
    wait_stb(1, "align1");
    pat[1] = 16'hEFFF;
    wait_stb(1, "db_a");
    m1_frame(16'hEFFF);
    check("db_once_joy2", 32'(if1.joy2), 32'h3F);
    check("db_once_raw",  32'(if1.raw),  32'hEFFF);
    pat[1] = 16'hFFFF;
    wait_stb(1, "db_b");
    m1_frame(16'hFFFF);
    check("db_back_joy2", 32'(if1.joy2), 32'h3F);
    pat[1] = 16'hEFFF;
    wait_stb(1, "db_c");
    m1_frame(16'hEFFF);
    check("db_first_joy2", 32'(if1.joy2), 32'h3F);
    wait_stb(1, "db_d");
    m1_frame(16'hEFFF);
    check("db_twice_joy2", 32'(if1.joy2), 32'h2F);
    check("db_twice_joy1", 32'(if1.joy1), 32'h3F);

    for (int i = 0; i < 8; i++) begin
      w = ($urandom_range(0, 1) == 1) ? m1prev : 16'($urandom);
      pat[1] = w;
      wait_stb(1, "rand1");
      m1_frame(w);
      check("rand1_raw",  32'(if1.raw),  32'(w));
      check("rand1_joy1", 32'(if1.joy1), 32'(e1));
      check("rand1_joy2", 32'(if1.joy2), 32'(e2));
    end

    // Fast receiver: CLKDIV=2, GAPTICKS=1.
    wait_load_fall(2, "fast_a", n);
    wait_load_fall(2, "fast_b", n);
    check("fast_period", 32'(n), 32'd70);
    wait_stb(2, "align2");
    for (int i = 0; i < 6; i++) begin
      w = 16'($urandom);
      pat[2] = w;
      wait_stb(2, "rand2");
      check("rand2_raw",  32'(if2.raw),  32'(w));
      check("rand2_joy1", 32'(if2.joy1), 32'(decode(w, 0)));
      check("rand2_joy2", 32'(if2.joy2), 32'(decode(w, 1)));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
